// File: rtl/layer_mem_pkg.sv
// Shared types, default sizes and the row/column address helper for the
// ping-pong layer result memory.
package layer_mem_pkg;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

    localparam int DEF_DATA_W = 128;
    localparam int DEF_MAP_W  = 14;

    // Linear bank address; the map holds at most 256 words, so 8 bits suffice.
    function automatic logic [7:0] addr(input logic [15:0] row,
                                        input logic [15:0] col,
                                        input int          map_w);
        return 8'(32'(row) * 32'(map_w) + 32'(col));
    endfunction

endpackage

// File: rtl/layer_result_bank.sv
// One-write one-read synchronous RAM used as a single ping-pong bank.
module layer_result_bank #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 196,
    parameter int AW     = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata_p1;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata_p1 <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata_p1;

endmodule

// File: rtl/layer_result_pingpong_mem.sv
// Two-bank ping-pong store for layer results: the producer fills one bank
// while the consumer reads the other full bank until it releases it.
module layer_result_pingpong_mem
    import layer_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int MAP_W  = DEF_MAP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              save_enable,
    input  logic [DATA_W-1:0] save_data_in,
    input  logic [15:0]       save_row_addr,
    input  logic [15:0]       save_col_addr,
    output logic              save_ready,
    input  logic              read_signal,
    input  logic [15:0]       read_row_addr,
    input  logic [15:0]       read_col_addr,
    output logic [DATA_W-1:0] read_data_out,
    output logic              read_valid,
    output logic              read_bank_ready,
    input  logic              read_release,
    output logic              oob_error
);

    // DEPTH must not exceed 256 so that the 8-bit linear address covers it.
    localparam int              DEPTH    = MAP_W * MAP_W;
    localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CNT_W    = 9;
    localparam logic [15:0]     MAP_LIM  = 16'(MAP_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

    bank_state_t      r_state [2];
    logic             r_wr_sel;
    logic             r_rd_sel;
    logic [CNT_W-1:0] r_fill_cnt;
    logic             r_oob;
    logic             r_rd_vld_p1;
    logic             r_rd_oob_p1;
    logic             r_rd_sel_p1;

    logic              w_wr_inrange;
    logic              w_rd_inrange;
    logic              w_wr_ok;
    logic              w_wr_oob;
    logic              w_rd_ok;
    logic              w_rel_ok;
    logic              w_fill_done;
    logic [AW-1:0]     w_wr_addr;
    logic [AW-1:0]     w_rd_addr;
    logic [DATA_W-1:0] w_bank_rdata [2];

    assign save_ready      = (r_state[r_wr_sel] != BANK_FULL);
    assign read_bank_ready = (r_state[r_rd_sel] == BANK_FULL);

    assign w_wr_inrange = (save_row_addr < MAP_LIM) && (save_col_addr < MAP_LIM);
    assign w_rd_inrange = (read_row_addr < MAP_LIM) && (read_col_addr < MAP_LIM);
    assign w_wr_ok      = save_enable && save_ready && w_wr_inrange;
    assign w_wr_oob     = save_enable && !w_wr_inrange;
    // Reads and releases are gated by a FULL read bank, so a FILLING bank is never read.
    assign w_rd_ok      = read_signal && read_bank_ready;
    assign w_rel_ok     = read_release && read_bank_ready;
    assign w_fill_done  = w_wr_ok && (r_fill_cnt == CNT_LAST);

    assign w_wr_addr = AW'(addr(save_row_addr, save_col_addr, MAP_W));
    assign w_rd_addr = AW'(addr(read_row_addr, read_col_addr, MAP_W));

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        layer_result_bank #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .AW     (AW)
        ) u_bank (
            .clk     (clk),
            .i_we    (w_wr_ok && (r_wr_sel == 1'(gi))),
            .i_waddr (w_wr_addr),
            .i_wdata (save_data_in),
            .i_re    (w_rd_ok && w_rd_inrange && (r_rd_sel == 1'(gi))),
            .i_raddr (w_rd_addr),
            .o_rdata (w_bank_rdata[gi])
        );
    end

    // Bank bookkeeping; fill completion and release always hit different banks.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state[0] <= BANK_EMPTY;
            r_state[1] <= BANK_EMPTY;
            r_wr_sel   <= 1'b0;
            r_rd_sel   <= 1'b0;
            r_fill_cnt <= '0;
            r_oob      <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                if (w_fill_done) begin
                    r_state[r_wr_sel] <= BANK_FULL;
                    r_fill_cnt        <= '0;
                    r_wr_sel          <= ~r_wr_sel;
                end else begin
                    r_state[r_wr_sel] <= BANK_FILLING;
                    r_fill_cnt        <= r_fill_cnt + 1'b1;
                end
            end
            if (w_rel_ok) begin
                r_state[r_rd_sel] <= BANK_EMPTY;
                r_rd_sel          <= ~r_rd_sel;
            end
            if (w_wr_oob || (w_rd_ok && !w_rd_inrange)) begin
                r_oob <= 1'b1;
            end
        end
    end

    // Stage p1: read response, bank and range captured with the request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_vld_p1 <= 1'b0;
        end else begin
            r_rd_vld_p1 <= w_rd_ok;
        end
        r_rd_oob_p1 <= !w_rd_inrange;
        r_rd_sel_p1 <= r_rd_sel;
    end

    assign read_valid    = r_rd_vld_p1;
    assign read_data_out = (r_rd_vld_p1 && !r_rd_oob_p1) ? w_bank_rdata[r_rd_sel_p1] : '0;
    assign oob_error     = r_oob;

endmodule

// File: tb/tb_layer_result_pingpong_mem.sv
// Directed bench for the ping-pong layer result memory at MAP_W=4 (DEPTH=16).
module tb_layer_result_pingpong_mem;
    import layer_mem_pkg::*;

    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk;
    logic          rst;
    logic          save_enable;
    logic [DW-1:0] save_data_in;
    logic [15:0]   save_row_addr;
    logic [15:0]   save_col_addr;
    logic          save_ready;
    logic          read_signal;
    logic [15:0]   read_row_addr;
    logic [15:0]   read_col_addr;
    logic [DW-1:0] read_data_out;
    logic          read_valid;
    logic          read_bank_ready;
    logic          read_release;
    logic          oob_error;

    int n_checks = 0;
    int n_fail   = 0;

    layer_result_pingpong_mem #(.DATA_W(DW), .MAP_W(MW)) dut (
        .clk             (clk),
        .rst             (rst),
        .save_enable     (save_enable),
        .save_data_in    (save_data_in),
        .save_row_addr   (save_row_addr),
        .save_col_addr   (save_col_addr),
        .save_ready      (save_ready),
        .read_signal     (read_signal),
        .read_row_addr   (read_row_addr),
        .read_col_addr   (read_col_addr),
        .read_data_out   (read_data_out),
        .read_valid      (read_valid),
        .read_bank_ready (read_bank_ready),
        .read_release    (read_release),
        .oob_error       (oob_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int r, input int c, input int d);
        save_enable   = 1'b1;
        save_row_addr = 16'(r);
        save_col_addr = 16'(c);
        save_data_in  = DW'(d);
        step();
        save_enable   = 1'b0;
    endtask

    task automatic rd(input int r, input int c);
        read_signal   = 1'b1;
        read_row_addr = 16'(r);
        read_col_addr = 16'(c);
        step();
        read_signal   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; save_enable = 1'b0; save_data_in = '0;
        save_row_addr = '0; save_col_addr = '0; read_signal = 1'b0;
        read_row_addr = '0; read_col_addr = '0; read_release = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_save_ready", save_ready, 1);
        check("rst_rd_ready", read_bank_ready, 0);
        check("rst_valid", read_valid, 0);
        check("rst_data", read_data_out, 0);
        check("rst_oob", oob_error, 0);

        // Fill bank0 with r*4+c
        for (int a = 0; a < 16; a++) begin
            wr(a / 4, a % 4, a);
            check("fill0_save_ready", save_ready, 1);
        end
        check("fill0_rd_ready", read_bank_ready, 1);
        check("fill0_wr_sel", dut.r_wr_sel, 1);
        check("fill0_cnt", dut.r_fill_cnt, 0);

        rd(2, 3);
        check("rd23_valid", read_valid, 1);
        check("rd23_data", read_data_out, 11);
        step();
        check("idle_valid", read_valid, 0);
        check("idle_data", read_data_out, 0);
        rd(1, 2);
        check("rd12_data", read_data_out, 6);
        rd(3, 3);
        check("rd33_data", read_data_out, 15);
        check("rd33_valid", read_valid, 1);

        // Out-of-range write is dropped and sets the sticky flag
        wr(4, 0, 55);
        check("oob_flag", oob_error, 1);
        check("oob_cnt", dut.r_fill_cnt, 0);
        check("oob_bank1_state", dut.r_state[1], BANK_EMPTY);

        // Fill bank1 with 100+a while bank0 is still held
        for (int a = 0; a < 16; a++) begin
            wr(a / 4, a % 4, 100 + a);
            check("fill1_save_ready", save_ready, (a < 15) ? 1 : 0);
        end
        wr(0, 0, 999);
        check("drop_cnt", dut.r_fill_cnt, 0);
        check("drop_state0", dut.r_state[0], BANK_FULL);
        check("drop_oob", oob_error, 1);
        rd(0, 0);
        check("old_bank0_data", read_data_out, 0);
        read_release = 1'b1;
        step();
        read_release = 1'b0;
        check("rel_save_ready", save_ready, 1);
        check("rel_rd_sel", dut.r_rd_sel, 1);
        check("rel_rd_ready", read_bank_ready, 1);
        rd(2, 3);
        check("rd_bank1_data", read_data_out, 111);

        // Refill bank0 with an overwritten first address
        wr(0, 0, 777);
        for (int a = 0; a < 14; a++) wr(a / 4, a % 4, 200 + a);
        check("fill_b0_cnt15", dut.r_fill_cnt, 15);
        check("fill_b0_state", dut.r_state[0], BANK_FILLING);
        save_enable = 1'b1; save_row_addr = 16'd3; save_col_addr = 16'd2; save_data_in = DW'(214);
        read_signal = 1'b1; read_row_addr = 16'd1; read_col_addr = 16'd1;
        read_release = 1'b1;
        step();
        save_enable = 1'b0; read_signal = 1'b0; read_release = 1'b0;
        check("sim_rd_valid", read_valid, 1);
        check("sim_rd_data", read_data_out, 105);
        check("sim_state0", dut.r_state[0], BANK_FULL);
        check("sim_state1", dut.r_state[1], BANK_EMPTY);
        check("sim_rd_sel", dut.r_rd_sel, 0);
        check("sim_wr_sel", dut.r_wr_sel, 1);
        check("sim_rd_ready", read_bank_ready, 1);
        check("sim_save_ready", save_ready, 1);
        rd(0, 0);
        check("overwrite_data", read_data_out, 200);
        rd(3, 2);
        check("last_write_data", read_data_out, 214);
        rd(0, 5);
        check("oob_rd_valid", read_valid, 1);
        check("oob_rd_data", read_data_out, 0);
        check("oob_sticky", oob_error, 1);

        // Reset in the middle of a fill
        for (int a = 0; a < 7; a++) wr(a / 4, a % 4, 300 + a);
        check("mid_cnt7", dut.r_fill_cnt, 7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_cnt", dut.r_fill_cnt, 0);
        check("mid_rst_save_ready", save_ready, 1);
        check("mid_rst_rd_ready", read_bank_ready, 0);
        check("mid_rst_oob", oob_error, 0);
        check("mid_rst_wr_sel", dut.r_wr_sel, 0);
        read_release = 1'b1;
        read_signal  = 1'b1; read_row_addr = 16'd0; read_col_addr = 16'd0;
        step();
        read_release = 1'b0; read_signal = 1'b0;
        check("ign_rel_rd_sel", dut.r_rd_sel, 0);
        check("ign_rd_valid", read_valid, 0);
        for (int a = 0; a < 15; a++) wr(a / 4, a % 4, 50 + a);
        check("refill15_rd_ready", read_bank_ready, 0);
        wr(3, 3, 65);
        check("refill16_rd_ready", read_bank_ready, 1);
        rd(3, 3);
        check("refill_data", read_data_out, 65);
        rd(0, 1);
        check("refill_data01", read_data_out, 51);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
